jtag_ahb_dr: RTL

JTAG-to-AHB-Lite access data register: a parametrised successor to the single-width AHB data register. It sits behind the TAP controller as the AHB-select DR. It shifts a command frame in from TDI and, on Update-DR, issues one AHB-Lite single word transfer. On Capture-DR it presents status and last read data for shifting out on TDO. It adds a bus-master FSM, sticky error and overrun status, and an optional address auto-increment mode.

---
 rtl/jtag_ahb_dr_if.sv | 24 ++
 rtl/jtag_ahb_dr.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/jtag_ahb_dr_if.sv
// AHB-Lite signal bundle between the JTAG AHB data register (master) and the bus (slave).
interface jtag_ahb_dr_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    output HADDR, HWRITE, HTRANS, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HTRANS, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/jtag_ahb_dr.sv
// JTAG AHB-select data register: shifts a command frame, issues one AHB-Lite single word transfer.
// Optional address auto-increment is enabled by defining JTAG_AHB_DR_AUTOINC_EN.
module jtag_ahb_dr #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic          TCK,
  input  logic          TRST,
  input  logic          TDI,
  output logic          TDO,
  input  logic          ahb_select,
  input  logic          dr_capture,
  input  logic          dr_shift,
  input  logic          dr_update,
  output logic          busy,
  jtag_ahb_dr_if.master ahb
);

  localparam int unsigned SR_W = 2 + ADDR_W + DATA_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  logic [SR_W-1:0]   sr_q, sr_d, cap_word;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d, cmd_addr;
  logic              hwrite_q, hwrite_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;

  logic do_capture, do_shift, do_update;
  logic cmd_accept, cmd_drop, data_done, err_event;

  // Strobe priority: capture > shift > update, all gated by the instruction select.
  assign do_capture = ahb_select & dr_capture;
  assign do_shift   = ahb_select & dr_shift & ~dr_capture;
  assign do_update  = ahb_select & dr_update & ~dr_capture & ~dr_shift;

  assign busy       = (state_q != StIdle);
  assign cmd_accept = do_update & ~busy;
  assign cmd_drop   = do_update & busy;
  assign data_done  = (state_q == StData) & ahb.HREADY;
  assign err_event  = data_done & ahb.HRESP;

`ifdef JTAG_AHB_DR_AUTOINC_EN
  assign cmd_addr = sr_q[1] ? (haddr_q + ADDR_W'(4)) : sr_q[ADDR_W+1:2];
`else
  assign cmd_addr = sr_q[ADDR_W+1:2];
`endif

  always_comb begin
    cap_word             = '0;
    cap_word[0]          = busy;
    cap_word[1]          = err_q;
    cap_word[2]          = ovr_q;
    cap_word[DATA_W+2:3] = rdata_q;
  end

  always_comb begin
    sr_d = sr_q;
    if (do_capture) begin
      sr_d = cap_word;
    end else if (do_shift) begin
      sr_d = {TDI, sr_q[SR_W-1:1]};
    end
  end

  // Read-to-clear on capture; a same-cycle event keeps the flag set.
  always_comb begin
    err_d = err_q;
    ovr_d = ovr_q;
    if (do_capture) begin
      err_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (err_event) begin
      err_d = 1'b1;
    end
    if (cmd_drop) begin
      ovr_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    htrans_d = HtransIdle;
    case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          state_d  = StAddr;
          haddr_d  = cmd_addr;
          hwrite_d = sr_q[0];
          htrans_d = HtransNonseq;
          if (sr_q[0]) begin
            hwdata_d = sr_q[SR_W-1:ADDR_W+2];
          end
        end
      end
      StAddr: begin
        state_d = StData;
      end
      StData: begin
        if (ahb.HREADY) begin
          state_d = StIdle;
          if (!hwrite_q) begin
            rdata_d = ahb.HRDATA;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      sr_q     <= '0;
      state_q  <= StIdle;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      htrans_q <= HtransIdle;
      hwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      htrans_q <= htrans_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  assign TDO        = sr_q[0];
  assign ahb.HADDR  = haddr_q;
  assign ahb.HWRITE = hwrite_q;
  assign ahb.HTRANS = htrans_q;
  assign ahb.HSIZE  = 3'b010;
  assign ahb.HWDATA = hwdata_q;

endmodule
